// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the 5-stage MIPS core.
// Captures the decoded control bundle and operands for EX, detects load-use
// hazards against the instruction in EX (one-cycle bubble + upstream stall),
// and supports flush (taken branch) and hold (downstream stall).
// Optional build macro: ID_EX_PERF_CNT_EN adds bubble_cnt_o / flush_cnt_o.
//
// Flow control: ex_valid_o marks a real instruction in EX. There is no ready
// signal; stall_o tells the upstream stages to hold PC and IF/ID so the same ID
// instruction is re-presented on the next cycle. A bubble is an all-zero
// bundle, so it can never write registers or memory.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic              regwrite_i,
  input  logic [3:0]        alu_op_i,
  input  logic              alu_src_i,
  input  logic [1:0]        reg_dst_i,
  input  logic              branch_i,
  input  logic [1:0]        mem_to_reg_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [DATA_W-1:0] pc4_i,
  input  logic [REG_AW-1:0] rs_addr_i,
  input  logic [REG_AW-1:0] rt_addr_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic [5:0]        funct_i,
  input  logic              flush_i,
  input  logic              hold_i,
`ifdef ID_EX_PERF_CNT_EN
  output logic [31:0]       bubble_cnt_o,
  output logic [31:0]       flush_cnt_o,
`endif
  output logic              stall_o,
  output logic              ex_valid_o,
  output logic              regwrite_o,
  output logic [3:0]        alu_op_o,
  output logic              alu_src_o,
  output logic [1:0]        reg_dst_o,
  output logic              branch_o,
  output logic [1:0]        mem_to_reg_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  output logic [DATA_W-1:0] imm_o,
  output logic [DATA_W-1:0] pc4_o,
  output logic [REG_AW-1:0] rs_addr_o,
  output logic [REG_AW-1:0] rt_addr_o,
  output logic [REG_AW-1:0] rd_addr_o,
  output logic [5:0]        funct_o
);

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic [3:0]        alu_op;
    logic              alu_src;
    logic [1:0]        reg_dst;
    logic              branch;
    logic [1:0]        mem_to_reg;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc4;
    logic [REG_AW-1:0] rs_addr;
    logic [REG_AW-1:0] rt_addr;
    logic [REG_AW-1:0] rd_addr;
    logic [5:0]        funct;
  } ex_bundle_t;

  ex_bundle_t ex_q;
  ex_bundle_t cap_d;
  logic       hazard;
  logic       illegal_mem;
  logic       regwrite_eff;

  // Load-use hazard against the load currently in EX, plus the stall request.
  always_comb begin
    hazard = id_valid_i & ex_q.valid & ex_q.mem_read & (ex_q.rt_addr != '0) &
             ((ex_q.rt_addr == rs_addr_i) | (ex_q.rt_addr == rt_addr_i));
    stall_o = rst_i & ~flush_i & (hold_i | hazard);
  end

  // Masked capture bundle: decoder don't-cares never reach EX.
  always_comb begin
    cap_d        = '0;
    illegal_mem  = mem_read_i & mem_write_i;
    regwrite_eff = regwrite_i & ~illegal_mem;
    if (id_valid_i) begin
      cap_d.valid      = 1'b1;
      cap_d.regwrite   = regwrite_eff;
      cap_d.alu_op     = alu_op_i;
      cap_d.alu_src    = alu_src_i;
      cap_d.reg_dst    = regwrite_eff ? reg_dst_i : 2'd0;
      cap_d.branch     = branch_i;
      cap_d.mem_to_reg = regwrite_eff ? mem_to_reg_i : 2'd0;
      cap_d.mem_read   = mem_read_i & ~illegal_mem;
      cap_d.mem_write  = mem_write_i & ~illegal_mem;
      cap_d.rs_data    = rs_data_i;
      cap_d.rt_data    = rt_data_i;
      cap_d.imm        = imm_i;
      cap_d.pc4        = pc4_i;
      cap_d.rs_addr    = rs_addr_i;
      cap_d.rt_addr    = rt_addr_i;
      cap_d.rd_addr    = rd_addr_i;
      cap_d.funct      = funct_i;
    end
  end

  // Pipeline register: flush beats hold, hold beats hazard, else capture.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_q <= '0;
    end else if (flush_i) begin
      ex_q <= '0;
    end else if (!hold_i) begin
      ex_q <= hazard ? '0 : cap_d;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  // Event counters for hazard bubbles and flushes; they freeze under hold.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bubble_cnt_o <= '0;
      flush_cnt_o  <= '0;
    end else if (flush_i) begin
      flush_cnt_o <= flush_cnt_o + 32'd1;
    end else if (!hold_i && hazard) begin
      bubble_cnt_o <= bubble_cnt_o + 32'd1;
    end
  end
`endif

  assign ex_valid_o   = ex_q.valid;
  assign regwrite_o   = ex_q.regwrite;
  assign alu_op_o     = ex_q.alu_op;
  assign alu_src_o    = ex_q.alu_src;
  assign reg_dst_o    = ex_q.reg_dst;
  assign branch_o     = ex_q.branch;
  assign mem_to_reg_o = ex_q.mem_to_reg;
  assign mem_read_o   = ex_q.mem_read;
  assign mem_write_o  = ex_q.mem_write;
  assign rs_data_o    = ex_q.rs_data;
  assign rt_data_o    = ex_q.rt_data;
  assign imm_o        = ex_q.imm;
  assign pc4_o        = ex_q.pc4;
  assign rs_addr_o    = ex_q.rs_addr;
  assign rt_addr_o    = ex_q.rt_addr;
  assign rd_addr_o    = ex_q.rd_addr;
  assign funct_o      = ex_q.funct;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: self-checking bench for id_ex_stage with an expected-bundle
// queue. Also exercises the counters when ID_EX_PERF_CNT_EN is defined.
module tb_id_ex_stage;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int OW = 14 + 4 * DATA_W + 3 * REG_AW + 6;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              id_valid_i, regwrite_i, alu_src_i, branch_i;
  logic [3:0]        alu_op_i;
  logic [1:0]        reg_dst_i, mem_to_reg_i;
  logic              mem_read_i, mem_write_i;
  logic [DATA_W-1:0] rs_data_i, rt_data_i, imm_i, pc4_i;
  logic [REG_AW-1:0] rs_addr_i, rt_addr_i, rd_addr_i;
  logic [5:0]        funct_i;
  logic              flush_i, hold_i;
  logic              stall_o, ex_valid_o, regwrite_o, alu_src_o, branch_o;
  logic [3:0]        alu_op_o;
  logic [1:0]        reg_dst_o, mem_to_reg_o;
  logic              mem_read_o, mem_write_o;
  logic [DATA_W-1:0] rs_data_o, rt_data_o, imm_o, pc4_o;
  logic [REG_AW-1:0] rs_addr_o, rt_addr_o, rd_addr_o;
  logic [5:0]        funct_o;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0]       bubble_cnt_o, flush_cnt_o;
`endif

  // Scoreboard and reference model state
  logic [OW-1:0]     exp_q[$];
  logic [OW-1:0]     m_vec;
  logic              m_valid, m_mem_read;
  logic [REG_AW-1:0] m_rt;
  logic [31:0]       m_bubble, m_flush;
  int                checks = 0;
  int                failures = 0;
  logic [OW-1:0]     out_vec;

  assign out_vec = {ex_valid_o, regwrite_o, alu_op_o, alu_src_o, reg_dst_o, branch_o,
                    mem_to_reg_o, mem_read_o, mem_write_o, rs_data_o, rt_data_o, imm_o,
                    pc4_o, rs_addr_o, rt_addr_o, rd_addr_o, funct_o};

  id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i), .regwrite_i(regwrite_i),
    .alu_op_i(alu_op_i), .alu_src_i(alu_src_i), .reg_dst_i(reg_dst_i), .branch_i(branch_i),
    .mem_to_reg_i(mem_to_reg_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i), .pc4_i(pc4_i),
    .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i), .rd_addr_i(rd_addr_i), .funct_i(funct_i),
    .flush_i(flush_i), .hold_i(hold_i),
`ifdef ID_EX_PERF_CNT_EN
    .bubble_cnt_o(bubble_cnt_o), .flush_cnt_o(flush_cnt_o),
`endif
    .stall_o(stall_o), .ex_valid_o(ex_valid_o), .regwrite_o(regwrite_o),
    .alu_op_o(alu_op_o), .alu_src_o(alu_src_o), .reg_dst_o(reg_dst_o), .branch_o(branch_o),
    .mem_to_reg_o(mem_to_reg_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .rs_data_o(rs_data_o), .rt_data_o(rt_data_o), .imm_o(imm_o), .pc4_o(pc4_o),
    .rs_addr_o(rs_addr_o), .rt_addr_o(rt_addr_o), .rd_addr_o(rd_addr_o), .funct_o(funct_o)
  );

  // Clock
  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic model_clear();
    m_vec = '0;
    m_valid = 1'b0;
    m_mem_read = 1'b0;
    m_rt = '0;
  endtask

  task automatic set_idle();
    id_valid_i = 0; regwrite_i = 0; alu_op_i = 0; alu_src_i = 0; reg_dst_i = 0;
    branch_i = 0; mem_to_reg_i = 0; mem_read_i = 0; mem_write_i = 0;
    rs_data_i = 0; rt_data_i = 0; imm_i = 0; pc4_i = 0;
    rs_addr_i = 0; rt_addr_i = 0; rd_addr_i = 0; funct_i = 0;
    flush_i = 0; hold_i = 0;
  endtask

  task automatic set_instr(input logic rw, input logic [3:0] aop, input logic asrc,
                           input logic [1:0] rdst, input logic br, input logic [1:0] m2r,
                           input logic mr, input logic mw, input logic [REG_AW-1:0] rs,
                           input logic [REG_AW-1:0] rt, input logic [REG_AW-1:0] rd,
                           input logic [DATA_W-1:0] rsd, input logic [DATA_W-1:0] immv);
    id_valid_i = 1; regwrite_i = rw; alu_op_i = aop; alu_src_i = asrc; reg_dst_i = rdst;
    branch_i = br; mem_to_reg_i = m2r; mem_read_i = mr; mem_write_i = mw;
    rs_addr_i = rs; rt_addr_i = rt; rd_addr_i = rd; rs_data_i = rsd; imm_i = immv;
    rt_data_i = rsd ^ 32'h5a5a_0000; pc4_i = 32'h0040_0000 + {27'd0, rd, 2'b00};
    funct_i = {1'b1, rd};
  endtask

  // One clock: check stall against the model, predict the next EX bundle,
  // then compare the DUT output after the edge.
  task automatic step();
    logic hz, es, ill, rw;
    #1;
    hz = id_valid_i & m_valid & m_mem_read & (m_rt != 0) &
         ((m_rt == rs_addr_i) | (m_rt == rt_addr_i));
    es = ~flush_i & (hold_i | hz);
    check_eq("stall", {{(OW-1){1'b0}}, stall_o}, {{(OW-1){1'b0}}, es});
    if (flush_i) begin
      model_clear();
      m_flush = m_flush + 1;
    end else if (hold_i) begin
      // frozen
    end else if (hz) begin
      model_clear();
      m_bubble = m_bubble + 1;
    end else if (!id_valid_i) begin
      model_clear();
    end else begin
      ill = mem_read_i & mem_write_i;
      rw = regwrite_i & ~ill;
      m_vec = {1'b1, rw, alu_op_i, alu_src_i, rw ? reg_dst_i : 2'd0, branch_i,
               rw ? mem_to_reg_i : 2'd0, mem_read_i & ~ill, mem_write_i & ~ill,
               rs_data_i, rt_data_i, imm_i, pc4_i, rs_addr_i, rt_addr_i, rd_addr_i, funct_i};
      m_valid = 1'b1;
      m_mem_read = mem_read_i & ~ill;
      m_rt = rt_addr_i;
    end
    exp_q.push_back(m_vec);
    @(posedge clk_i);
    #1;
    if (exp_q.size() == 0) begin
      check_eq("queue_empty", '0, {{(OW-1){1'b0}}, 1'b1});
    end else begin
      check_eq("ex_bundle", out_vec, exp_q.pop_front());
    end
`ifdef ID_EX_PERF_CNT_EN
    check_eq("bubble_cnt", {{(OW-32){1'b0}}, bubble_cnt_o}, {{(OW-32){1'b0}}, m_bubble});
    check_eq("flush_cnt", {{(OW-32){1'b0}}, flush_cnt_o}, {{(OW-32){1'b0}}, m_flush});
`endif
    @(negedge clk_i);
  endtask

  initial begin
    set_idle();
    model_clear();
    m_bubble = 0;
    m_flush = 0;
    // Reset state
    rst_i = 0;
    hold_i = 1;
    #12;
    check_eq("reset_outputs", out_vec, '0);
    check_eq("reset_stall", {{(OW-1){1'b0}}, stall_o}, '0);
    hold_i = 0;
    @(negedge clk_i);
    rst_i = 1;

    // Normal capture: addi $t1,$t0,5
    set_instr(1, 4'd6, 1, 2'd0, 0, 2'd0, 0, 0, 5'd8, 5'd9, 5'd0, 32'h10, 32'd5);
    step();
    check_eq("addi_alu_op", {{(OW-4){1'b0}}, alu_op_o}, {{(OW-4){1'b0}}, 4'd6});
    check_eq("addi_imm", {{(OW-32){1'b0}}, imm_o}, {{(OW-32){1'b0}}, 32'd5});
    check_eq("addi_rs_data", {{(OW-32){1'b0}}, rs_data_o}, {{(OW-32){1'b0}}, 32'h10});

    // Load-use: lw rt=9 then add rs=9 (stall + bubble, then captured)
    set_instr(1, 4'd2, 1, 2'd0, 0, 2'd1, 1, 0, 5'd8, 5'd9, 5'd0, 32'h100, 32'd4);
    step();
    set_instr(1, 4'd2, 0, 2'd1, 0, 2'd0, 0, 0, 5'd9, 5'd10, 5'd11, 32'h7, 32'd0);
    step();
    check_eq("lu_bubble_valid", {{(OW-1){1'b0}}, ex_valid_o}, '0);
    step();
    check_eq("lu_capture_valid", {{(OW-1){1'b0}}, ex_valid_o}, {{(OW-1){1'b0}}, 1'b1});

    // Load into $0 never stalls
    set_instr(1, 4'd2, 1, 2'd0, 0, 2'd1, 1, 0, 5'd8, 5'd0, 5'd0, 32'h100, 32'd8);
    step();
    set_instr(1, 4'd2, 0, 2'd1, 0, 2'd0, 0, 0, 5'd0, 5'd0, 5'd12, 32'h3, 32'd0);
    step();

    // Flush while a hazard is present
    set_instr(1, 4'd2, 1, 2'd0, 0, 2'd1, 1, 0, 5'd8, 5'd9, 5'd0, 32'h200, 32'd0);
    step();
    set_instr(1, 4'd2, 0, 2'd1, 0, 2'd0, 0, 0, 5'd9, 5'd9, 5'd13, 32'h4, 32'd0);
    flush_i = 1;
    step();
    flush_i = 0;

    // Hold three cycles over a pending hazard, then release
    set_instr(1, 4'd2, 1, 2'd0, 0, 2'd1, 1, 0, 5'd8, 5'd9, 5'd0, 32'h300, 32'd12);
    step();
    for (int i = 0; i < 3; i++) begin
      set_instr(1, 4'd3, 0, 2'd1, 0, 2'd0, 0, 0, 5'd9, 5'd2, 5'd14, 32'h40 + i, 32'd0);
      hold_i = 1;
      step();
    end
    hold_i = 0;
    step();
    step();

    // Masking: beq and illegal load+store
    set_instr(0, 4'd1, 0, 2'd1, 1, 2'd3, 0, 0, 5'd3, 5'd4, 5'd0, 32'h11, 32'hffff_fff8);
    step();
    set_instr(1, 4'd2, 1, 2'd0, 0, 2'd0, 1, 1, 5'd3, 5'd4, 5'd0, 32'h22, 32'd16);
    step();
    set_instr(1, 4'd7, 1, 2'd1, 1, 2'd2, 0, 0, 5'd5, 5'd6, 5'd7, 32'h33, 32'd1);
    id_valid_i = 0;
    step();

`ifdef ID_EX_PERF_CNT_EN
    check_eq("perf_bubble_2", {{(OW-32){1'b0}}, bubble_cnt_o}, {{(OW-32){1'b0}}, 32'd2});
    check_eq("perf_flush_1", {{(OW-32){1'b0}}, flush_cnt_o}, {{(OW-32){1'b0}}, 32'd1});
`endif

    // Reset mid-stall with valid contents
    set_instr(1, 4'd6, 1, 2'd0, 0, 2'd0, 0, 0, 5'd1, 5'd2, 5'd0, 32'h55, 32'd9);
    step();
    hold_i = 1;
    #1;
    check_eq("pre_reset_stall", {{(OW-1){1'b0}}, stall_o}, {{(OW-1){1'b0}}, 1'b1});
    rst_i = 0;
    #1;
    check_eq("midreset_outputs", out_vec, '0);
    check_eq("midreset_stall", {{(OW-1){1'b0}}, stall_o}, '0);
    model_clear();
    m_bubble = 0;
    m_flush = 0;
    @(negedge clk_i);
    rst_i = 1;
    hold_i = 0;

    // Random traffic with small register numbers to provoke hazards
    for (int n = 0; n < 300; n++) begin
      set_instr(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
                $urandom, $urandom);
      id_valid_i = ($urandom_range(0, 7) != 0);
      flush_i = ($urandom_range(0, 9) == 0);
      hold_i = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global timeout
  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
